// File: rtl/laser_pool_pkg.sv
// Shared types and constants for the player-laser pool.
//   CoordWidth   : default coordinate width for sx/sy/gun position
//   H_RES/V_RES  : visible screen size
//   laser_slot_t : one laser record {valid, x, y} at the default width
//   colour_t     : 4-bit-per-channel {r, g, b}
//   idx_width()  : index width for an N-entry array (at least 1 bit)
package laser_pool_pkg;

  localparam int unsigned CoordWidth = 10;
  localparam int unsigned H_RES      = 640;
  localparam int unsigned V_RES      = 480;

  typedef struct packed {
    logic                  valid;
    logic [CoordWidth-1:0] x;
    logic [CoordWidth-1:0] y;
  } laser_slot_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } colour_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/laser_pool_if.sv
// Bundle between the player/scan logic and the laser pool.
//   master : drives frame/fire/gun position/scan position/hit, observes laser outputs
//   slave  : the laser pool side
interface laser_pool_if
  import laser_pool_pkg::*;
#(
  parameter int unsigned CORDW = CoordWidth,
  parameter int unsigned CNTW  = 3
);
  logic             frame_i;
  logic             fire_i;
  logic [CORDW-1:0] gun_pos_i;
  logic [CORDW-1:0] sx_i;
  logic [CORDW-1:0] sy_i;
  logic             hit_i;
  logic             laser_pixel_o;
  logic [3:0]       laser_r_o;
  logic [3:0]       laser_g_o;
  logic [3:0]       laser_b_o;
  logic [CNTW-1:0]  active_count_o;
  logic             fired_o;

  modport master (
    output frame_i, fire_i, gun_pos_i, sx_i, sy_i, hit_i,
    input  laser_pixel_o, laser_r_o, laser_g_o, laser_b_o, active_count_o, fired_o
  );

  modport slave (
    input  frame_i, fire_i, gun_pos_i, sx_i, sy_i, hit_i,
    output laser_pixel_o, laser_r_o, laser_g_o, laser_b_o, active_count_o, fired_o
  );
endinterface

// File: rtl/laser_slot.sv
// One laser slot: holds {valid, x, y}, moves up per frame, retires near the
// screen top, loads on spawn, clears on hit, and tests the scan pixel.
//   frame_i   : frame tick, move/retire
//   spawn_i   : load x=spawn_x_i, y=SPAWN_Y_P (only asserted for a free slot)
//   hit_clr_i : invalidate; wins over a coincident frame move
//   sx_i/sy_i : current scan pixel
//   valid_o   : registered valid; valid_d_o is its next-state value
//   match_o   : scan pixel lies inside this (valid) laser
module laser_slot
  import laser_pool_pkg::*;
#(
  parameter int unsigned CORDW     = CoordWidth,
  parameter int unsigned SPAWN_Y_P = 396,
  parameter int unsigned TOP_Y_P   = 8,
  parameter int unsigned SPEED_P   = 4,
  parameter int unsigned WIDTH_P   = 2,
  parameter int unsigned HEIGHT_P  = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             frame_i,
  input  logic             spawn_i,
  input  logic [CORDW-1:0] spawn_x_i,
  input  logic             hit_clr_i,
  input  logic [CORDW-1:0] sx_i,
  input  logic [CORDW-1:0] sy_i,
  output logic             valid_o,
  output logic             valid_d_o,
  output logic             match_o
);

  localparam logic [CORDW:0] TopLimit = (CORDW+1)'(TOP_Y_P + SPEED_P);

  logic             valid_q, valid_d;
  logic [CORDW-1:0] x_q, x_d;
  logic [CORDW-1:0] y_q, y_d;

  always_comb begin
    valid_d = valid_q;
    x_d     = x_q;
    y_d     = y_q;
    if (hit_clr_i) begin
      valid_d = 1'b0;
    end else if (frame_i && valid_q) begin
      if ({1'b0, y_q} < TopLimit) begin
        valid_d = 1'b0;
      end else begin
        y_d = y_q - CORDW'(SPEED_P);
      end
    end
    if (spawn_i) begin
      valid_d = 1'b1;
      x_d     = spawn_x_i;
      y_d     = CORDW'(SPAWN_Y_P);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      valid_q <= valid_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  // One extra bit so x+WIDTH / y+HEIGHT never wrap at the coordinate limit.
  logic [CORDW:0] sx_e, sy_e, x_e, y_e;
  assign sx_e = {1'b0, sx_i};
  assign sy_e = {1'b0, sy_i};
  assign x_e  = {1'b0, x_q};
  assign y_e  = {1'b0, y_q};

  assign match_o = valid_q
                && (sx_e >= x_e) && (sx_e < x_e + (CORDW+1)'(WIDTH_P))
                && (sy_e >= y_e) && (sy_e < y_e + (CORDW+1)'(HEIGHT_P));

  assign valid_o   = valid_q;
  assign valid_d_o = valid_d;

endmodule

// File: rtl/laser_pool.sv
// Pool of N_LASERS_P player lasers. Spawns on a fire press at the gun x,
// moves every laser up once per frame, retires at the top or on hit, and
// produces a registered per-pixel laser flag/colour for the paint mux.
//   clk_i   : pixel clock
//   reset_i : synchronous, active-high
//   bus     : frame/fire/gun/scan/hit in; laser_pixel/colour/active_count/fired out
// The pixel flag has one cycle of latency; the top level delays de/sync to match.
module laser_pool
  import laser_pool_pkg::*;
#(
  parameter int unsigned CORDW      = CoordWidth,
  parameter int unsigned N_LASERS_P = 4,
  parameter int unsigned SPAWN_Y_P  = 396,
  parameter int unsigned TOP_Y_P    = 8,
  parameter int unsigned SPEED_P    = 4,
  parameter int unsigned COOLDOWN_P = 10,
  parameter int unsigned WIDTH_P    = 2,
  parameter int unsigned HEIGHT_P   = 8,
  parameter logic [11:0] COLOR_P    = 12'hFF0
) (
  input logic         clk_i,
  input logic         reset_i,
  laser_pool_if.slave bus
);

  localparam int unsigned CntW = $clog2(N_LASERS_P + 1);
  localparam int unsigned IdxW = idx_width(N_LASERS_P);
  localparam int unsigned CdW  = (COOLDOWN_P > 0) ? $clog2(COOLDOWN_P + 1) : 1;

  logic [N_LASERS_P-1:0] valid, valid_nx, match, hit_clr, spawn_sel, spawn_en;
  logic                  free_any, spawn;

  logic            fire_q, fire_d;
  logic            pending_q, pending_d;
  logic [CdW-1:0]  cd_q, cd_d;
  logic            pix_q, pix_d;
  logic [IdxW-1:0] hit_idx_q, hit_idx_d;
  logic            fired_q, fired_d;
  logic [CntW-1:0] count_q, count_d;

  for (genvar i = 0; i < N_LASERS_P; i++) begin : g_slot
    laser_slot #(
      .CORDW    (CORDW),
      .SPAWN_Y_P(SPAWN_Y_P),
      .TOP_Y_P  (TOP_Y_P),
      .SPEED_P  (SPEED_P),
      .WIDTH_P  (WIDTH_P),
      .HEIGHT_P (HEIGHT_P)
    ) u_slot (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .frame_i  (bus.frame_i),
      .spawn_i  (spawn_en[i]),
      .spawn_x_i(bus.gun_pos_i),
      .hit_clr_i(hit_clr[i]),
      .sx_i     (bus.sx_i),
      .sy_i     (bus.sy_i),
      .valid_o  (valid[i]),
      .valid_d_o(valid_nx[i]),
      .match_o  (match[i])
    );
  end

  // Hit decode and lowest-free-slot priority encoder. A slot being hit this
  // cycle is not offered for spawn even though it becomes free.
  always_comb begin
    hit_clr   = '0;
    spawn_sel = '0;
    free_any  = 1'b0;
    for (int unsigned i = 0; i < N_LASERS_P; i++) begin
      hit_clr[i] = bus.hit_i && pix_q && (hit_idx_q == IdxW'(i));
    end
    for (int unsigned i = 0; i < N_LASERS_P; i++) begin
      if (!free_any && !valid[i] && !hit_clr[i]) begin
        spawn_sel[i] = 1'b1;
        free_any     = 1'b1;
      end
    end
    spawn    = bus.frame_i && pending_q && (cd_q == '0) && free_any;
    spawn_en = spawn ? spawn_sel : '0;
  end

  always_comb begin
    fire_d    = bus.fire_i;
    pending_d = pending_q;
    if (bus.frame_i) begin
      pending_d = 1'b0;
    end else if (bus.fire_i && !fire_q) begin
      pending_d = 1'b1;
    end

    // A blocked spawn (all slots busy) leaves the counter at zero.
    cd_d = cd_q;
    if (spawn) begin
      cd_d = CdW'(COOLDOWN_P);
    end else if (bus.frame_i && (cd_q != '0)) begin
      cd_d = cd_q - 1'b1;
    end

    pix_d     = |match;
    hit_idx_d = '0;
    for (int i = N_LASERS_P - 1; i >= 0; i--) begin
      if (match[i]) hit_idx_d = IdxW'(i);
    end

    // Counted from next-state valids so the count lines up with the slots.
    count_d = '0;
    for (int unsigned i = 0; i < N_LASERS_P; i++) begin
      count_d = count_d + CntW'(valid_nx[i]);
    end

    fired_d = spawn;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      fire_q    <= 1'b0;
      pending_q <= 1'b0;
      cd_q      <= '0;
      pix_q     <= 1'b0;
      hit_idx_q <= '0;
      fired_q   <= 1'b0;
      count_q   <= '0;
    end else begin
      fire_q    <= fire_d;
      pending_q <= pending_d;
      cd_q      <= cd_d;
      pix_q     <= pix_d;
      hit_idx_q <= hit_idx_d;
      fired_q   <= fired_d;
      count_q   <= count_d;
    end
  end

  colour_t colour;
  assign colour = pix_q ? colour_t'(COLOR_P) : '0;

  assign bus.laser_pixel_o  = pix_q;
  assign bus.laser_r_o      = colour.r;
  assign bus.laser_g_o      = colour.g;
  assign bus.laser_b_o      = colour.b;
  assign bus.active_count_o = count_q;
  assign bus.fired_o        = fired_q;

endmodule
